// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: table lookup (S1), MSB-first bit packing into OUT_W words, explicit flush.
// Define HUFF_ESCAPE_EN to emit ESC_CODE + raw symbol for table entries with length 0.
module huffman_stream_encoder #(
  parameter int                 SYM_W    = 8,
  parameter int                 MAX_LEN  = 16,
  parameter int                 OUT_W    = 16,
  parameter logic [MAX_LEN-1:0] ESC_CODE = 'b1111,
  parameter int                 ESC_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         tbl_we,
  input  logic [SYM_W-1:0]             tbl_addr,
  input  logic [MAX_LEN-1:0]           tbl_code,
  input  logic [$clog2(MAX_LEN+1)-1:0] tbl_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SYM_W-1:0]             data_in,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             data_out,
  output logic [$clog2(OUT_W+1)-1:0]   out_bits,
  output logic                         out_last
);
  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam int OB_W  = $clog2(OUT_W+1);
  localparam int ACC_W = OUT_W + 2*MAX_LEN;
  localparam int CNT_W = $clog2(ACC_W+1);

  if (ESC_LEN + SYM_W > MAX_LEN || (ESC_CODE >> ESC_LEN) != '0) begin : g_bad_esc
    $error("escape prefix plus raw symbol does not fit in MAX_LEN");
  end

  typedef enum logic [1:0] {RUN, DRAIN, LAST} state_t;

  state_t                   state;
  logic [LEN_W+MAX_LEN-1:0] tbl [2**SYM_W];
  logic [1:0]               vld_pipe;   // [0]: S1 holds a looked-up symbol, [1]: appended last cycle
  logic [MAX_LEN-1:0]       s1_code;
  logic [LEN_W-1:0]         s1_len;
  logic [ACC_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic                     armed;

  logic [MAX_LEN-1:0]       app_code;
  logic [MAX_LEN-1:0]       app_mask;
  logic [LEN_W-1:0]         app_len;
  logic [ACC_W-1:0]         app_bits;
  logic [ACC_W-1:0]         sum_acc;
  logic [CNT_W-1:0]         sum_cnt;
  logic                     full;
  logic                     fire;

  // Table storage is deliberately not reset; it must be loaded while enable=0.
  always_ff @(posedge clk) begin
    if (tbl_we && !enable) tbl[tbl_addr] <= {tbl_len, tbl_code};
    {s1_len, s1_code} <= tbl[data_in];
  end

`ifdef HUFF_ESCAPE_EN
  logic [SYM_W-1:0] s1_sym;
  always_ff @(posedge clk) s1_sym <= data_in;
`endif

  always_comb begin
    app_code = s1_code;
    app_len  = s1_len;
`ifdef HUFF_ESCAPE_EN
    if (s1_len == '0) begin
      app_code = (ESC_CODE << SYM_W) | MAX_LEN'(s1_sym);
      app_len  = LEN_W'(ESC_LEN + SYM_W);
    end
`endif
    if (!vld_pipe[0]) app_len = '0;
    app_mask = ~({MAX_LEN{1'b1}} << app_len);
    // Place the code directly below the cnt bits already held at the top of acc.
    app_bits = {{(ACC_W-MAX_LEN){1'b0}}, app_code & app_mask}
               << (ACC_W - int'(cnt) - int'(app_len));
    sum_acc  = acc | app_bits;
    sum_cnt  = cnt + CNT_W'(app_len);
  end

  assign full      = cnt >= CNT_W'(OUT_W);
  assign out_valid = full || state == LAST;
  assign fire      = out_valid && out_ready;
  assign in_ready  = armed && enable && state == RUN && !full;
  assign data_out  = acc[ACC_W-1 -: OUT_W];
  assign out_bits  = (state == LAST) ? OB_W'(cnt) : (full ? OB_W'(OUT_W) : '0);
  assign out_last  = state == LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      vld_pipe <= '0;
      acc      <= '0;
      cnt      <= '0;
      armed    <= 1'b0;
    end else begin
      armed    <= 1'b1;
      vld_pipe <= {vld_pipe[0], in_valid && in_ready};
      if (state == LAST) begin
        if (out_ready) begin
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        if (fire) begin
          acc <= sum_acc << OUT_W;
          cnt <= sum_cnt - CNT_W'(OUT_W);
        end else begin
          acc <= sum_acc;
          cnt <= sum_cnt;
        end
        if (state == RUN && flush)
          state <= DRAIN;
        else if (state == DRAIN && vld_pipe == '0 && !full)
          state <= (cnt != '0) ? LAST : RUN;
      end
    end
  end
endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Directed bench for huffman_stream_encoder: expected words queued at stimulus time, checked on output.
module tb_huffman_stream_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        tbl_we = 1'b0;
  logic [7:0]  tbl_addr = '0;
  logic [15:0] tbl_code = '0;
  logic [4:0]  tbl_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  data_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] data_out;
  logic [4:0]  out_bits;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  bits;
    logic        last;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  huffman_stream_encoder dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_bits(out_bits), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] c, input logic [4:0] l);
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    logic ok;
    int   n;
    in_valid = 1'b1; data_in = s; n = 0;
    do begin
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    check("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_stream();
    send(8'd5); send(8'd68); send(8'd50); send(8'd100); send(8'd150);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic [4:0] b, input logic l);
    exp_t e;
    e.data = d; e.bits = b; e.last = l;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, sb.size(), 0);
    sb.delete();
    repeat (3) tick();
  endtask

  // Scoreboard side: every accepted output word must match the head of the queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("word_data", {16'd0, data_out}, {16'd0, mon_e.data});
        check("word_bits", {27'd0, out_bits}, {27'd0, mon_e.bits});
        check("word_last", {31'd0, out_last}, {31'd0, mon_e.last});
      end
    end
  end

  initial begin
    int n;
    enable = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_bits", {27'd0, out_bits}, 32'd0);
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    load(8'd5, 16'h0002, 5'd2);
    load(8'd68, 16'h0006, 5'd3);
    load(8'd50, 16'h0000, 5'd1);
    load(8'd100, 16'h000E, 5'd4);
    load(8'd150, 16'hABCD, 5'd16);
    load(8'd200, 16'h0000, 5'd0);
    enable = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic stream and flush
    push(16'hB3AA, 5'd16, 1'b0);
    push(16'hF340, 5'd10, 1'b1);
    send_stream();
    do_flush();
    wait_drain("t1_drain");
    check("t1_back_to_run", {31'd0, in_ready}, 32'd1);

    // 2: same stream under 20 cycles of backpressure
    out_ready = 1'b0;
    push(16'hB3AA, 5'd16, 1'b0);
    push(16'hF340, 5'd10, 1'b1);
    send_stream();
    repeat (2) tick();
    check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    do_flush();
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        check("t2_hold_data", {16'd0, data_out}, 32'h0000B3AA);
        check("t2_hold_last", {31'd0, out_last}, 32'd0);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: zero-length entry
`ifdef HUFF_ESCAPE_EN
    push(16'hFC80, 5'd12, 1'b1);
    send(8'd200);
    do_flush();
    wait_drain("t3_drain");
`else
    send(8'd200);
    do_flush();
    repeat (8) tick();
    check("t3_no_valid", {31'd0, out_valid}, 32'd0);
`endif
    check("t3_in_ready", {31'd0, in_ready}, 32'd1);

    // 4: flush with nothing pending
    do_flush();
    n = 0;
    while (!in_ready && n < 3) begin
      tick();
      n++;
    end
    check("t4_ready_in_3", {31'd0, in_ready}, 32'd1);
    check("t4_no_valid", {31'd0, out_valid}, 32'd0);

    // 5: reset with 10 bits pending
    send(8'd5); send(8'd68); send(8'd50); send(8'd100);
    repeat (3) tick();
    check("t5_pre_valid", {31'd0, out_valid}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_data", {16'd0, data_out}, 32'd0);
    check("t5_rst_bits", {27'd0, out_bits}, 32'd0);
    check("t5_rst_last", {31'd0, out_last}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    do_flush();
    repeat (8) tick();
    check("t5_no_emit", {31'd0, out_valid}, 32'd0);

    // 6: table write ignored while enabled; 8 x '10' fills exactly one word
    tbl_we = 1'b1; tbl_addr = 8'd5; tbl_code = 16'h0007; tbl_len = 5'd3;
    tick();
    tbl_we = 1'b0;
    push(16'hAAAA, 5'd16, 1'b0);
    for (int i = 0; i < 8; i++) send(8'd5);
    wait_drain("t6_drain");
    do_flush();
    repeat (6) tick();
    check("t6_exact_no_last", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);

    // single 16-bit code: full word, then an empty flush
    push(16'hABCD, 5'd16, 1'b0);
    send(8'd150);
    do_flush();
    wait_drain("t7_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
